// File: rtl/regfile_wb_queue.sv
// In-order writeback commit queue feeding the flip-flop register file ports.
// Optional forwarding lookup enabled by defining REGFILE_WB_QUEUE_FWD_EN.
module regfile_wb_queue #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter int unsigned DEPTH          = 8,
    parameter bit          DROP_X0        = 1'b1
`ifdef REGFILE_WB_QUEUE_FWD_EN
    ,
    parameter int unsigned NR_READ_PORTS  = 2
`endif
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [NR_WRITE_PORTS-1:0]                     in_valid_i,
    input  logic [NR_WRITE_PORTS-1:0][4:0]                in_waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]     in_wdata_i,
    output logic                                          in_ready_o,
    input  logic                                          stall_i,
    output logic [NR_WRITE_PORTS-1:0][4:0]                waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]     wdata_o,
    output logic [NR_WRITE_PORTS-1:0]                     we_o,
    output logic [$clog2(DEPTH):0]                        count_o,
    output logic                                          empty_o,
    output logic                                          full_o
`ifdef REGFILE_WB_QUEUE_FWD_EN
    ,
    input  logic [NR_READ_PORTS-1:0][4:0]                 fwd_raddr_i,
    output logic [NR_READ_PORTS-1:0]                      fwd_hit_o,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]      fwd_data_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LANES_C = CW'(NR_WRITE_PORTS);

    logic [4:0]            mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic [NR_WRITE_PORTS-1:0] lane_ok;
    logic [CW-1:0]             lane_off [NR_WRITE_PORTS];
    logic [CW-1:0]             enq_cnt;
    logic [CW-1:0]             drain_cnt;

    // Registered count only: a pop this cycle does not free a slot early.
    assign in_ready_o = (DEPTH_C - count_q) >= LANES_C;
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DEPTH_C);

    always_comb begin
        lane_ok = '0;
        enq_cnt = '0;
        for (int l = 0; l < NR_WRITE_PORTS; l++) begin
            lane_ok[l]  = in_valid_i[l] &&
                          !(DROP_X0 && in_waddr_i[l] == 5'd0);
            lane_off[l] = enq_cnt;
            enq_cnt     = enq_cnt + CW'(lane_ok[l]);
        end
        if (!in_ready_o) begin
            enq_cnt = '0;
        end
    end

    always_comb begin
        if (stall_i) begin
            drain_cnt = '0;
        end else if (count_q < LANES_C) begin
            drain_cnt = count_q;
        end else begin
            drain_cnt = LANES_C;
        end
    end

    always_comb begin
        we_o    = '0;
        waddr_o = '0;
        wdata_o = '0;
        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
            if (CW'(k) < drain_cnt) begin
                we_o[k]    = 1'b1;
                waddr_o[k] = mem_addr[rd_ptr_q + PW'(k)];
                wdata_o[k] = mem_data[rd_ptr_q + PW'(k)];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + drain_cnt[PW-1:0];
            wr_ptr_q <= wr_ptr_q + enq_cnt[PW-1:0];
            count_q  <= count_q + enq_cnt - drain_cnt;
        end
    end

    // Storage carries no reset; occupancy alone defines what is live.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < NR_WRITE_PORTS; l++) begin
            if (in_ready_o && lane_ok[l]) begin
                mem_addr[wr_ptr_q + lane_off[l][PW-1:0]] <= in_waddr_i[l];
                mem_data[wr_ptr_q + lane_off[l][PW-1:0]] <= in_wdata_i[l];
            end
        end
    end

`ifdef REGFILE_WB_QUEUE_FWD_EN
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit_o  = '0;
        fwd_data_o = '0;
        for (int r = 0; r < NR_READ_PORTS; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < count_q &&
                    mem_addr[rd_ptr_q + PW'(i)] == fwd_raddr_i[r] &&
                    !(DROP_X0 && fwd_raddr_i[r] == 5'd0)) begin
                    fwd_hit_o[r]  = 1'b1;
                    fwd_data_o[r] = mem_data[rd_ptr_q + PW'(i)];
                end
            end
        end
    end
`endif

    hold_while_blocked: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (!in_ready_o && |in_valid_i) |=>
        ($stable(in_valid_i) && $stable(in_waddr_i) &&
         $stable(in_wdata_i)));

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue (default DEPTH=8, 2 lanes, DROP_X0=1).
// Covers reset, compaction, x0 drop, stall/full, wrap order and mid-run reset.
module tb_regfile_wb_queue;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [1:0]            in_valid_i;
    logic [1:0][4:0]       in_waddr_i;
    logic [1:0][63:0]      in_wdata_i;
    logic                  in_ready_o;
    logic                  stall_i;
    logic [1:0][4:0]       waddr_o;
    logic [1:0][63:0]      wdata_o;
    logic [1:0]            we_o;
    logic [3:0]            count_o;
    logic                  empty_o;
    logic                  full_o;
`ifdef REGFILE_WB_QUEUE_FWD_EN
    logic [1:0][4:0]       fwd_raddr_i;
    logic [1:0]            fwd_hit_o;
    logic [1:0][63:0]      fwd_data_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] rf [32];

    regfile_wb_queue dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_waddr_i (in_waddr_i),
        .in_wdata_i (in_wdata_i),
        .in_ready_o (in_ready_o),
        .stall_i    (stall_i),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .we_o       (we_o),
        .count_o    (count_o),
        .empty_o    (empty_o),
        .full_o     (full_o)
`ifdef REGFILE_WB_QUEUE_FWD_EN
        ,
        .fwd_raddr_i(fwd_raddr_i),
        .fwd_hit_o  (fwd_hit_o),
        .fwd_data_o (fwd_data_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Regfile model: later port assignment wins on equal address.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (we_o[k]) rf[waddr_o[k]] <= wdata_o[k];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed hang, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic lanes(input logic [1:0] v,
                         input logic [4:0] a0, input logic [63:0] d0,
                         input logic [4:0] a1, input logic [63:0] d1);
        in_valid_i    = v;
        in_waddr_i[0] = a0;
        in_wdata_i[0] = d0;
        in_waddr_i[1] = a1;
        in_wdata_i[1] = d1;
    endtask

    logic [4:0]  q_a [$];
    logic [63:0] q_d [$];
    int          i_enq;
    int          cyc;
    int          n_exp;
    logic        exp_rdy;

    initial begin
        rst_i   = 1'b1;
        stall_i = 1'b0;
        lanes(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
`ifdef REGFILE_WB_QUEUE_FWD_EN
        fwd_raddr_i = '0;
`endif
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_we", 64'(we_o), 64'h0);
        chk("rst_count", 64'(count_o), 64'h0);
        chk("rst_empty", 64'(empty_o), 64'h1);
        chk("rst_full", 64'(full_o), 64'h0);
        chk("rst_ready", 64'(in_ready_o), 64'h1);

        // Two lanes in one cycle, drained next cycle
        lanes(2'b11, 5'd5, 64'hA5, 5'd6, 64'h5A);
        #1;
        chk("pass_thru_we", 64'(we_o), 64'h0);
        tick();
        lanes(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        #1;
        chk("pair_we", 64'(we_o), 64'h3);
        chk("pair_a0", 64'(waddr_o[0]), 64'd5);
        chk("pair_a1", 64'(waddr_o[1]), 64'd6);
        chk("pair_d0", wdata_o[0], 64'hA5);
        chk("pair_d1", wdata_o[1], 64'h5A);
        chk("pair_count", 64'(count_o), 64'd2);
        tick();
        chk("pair_we_after", 64'(we_o), 64'h0);
        chk("pair_empty", 64'(empty_o), 64'h1);
        chk("pair_a0_idle", 64'(waddr_o[0]), 64'h0);

        // x0 dropped, lane 1 compacted into port 0
        lanes(2'b11, 5'd0, 64'hFF, 5'd7, 64'h11);
        #1;
        tick();
        lanes(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        #1;
        chk("x0_count", 64'(count_o), 64'd1);
        chk("x0_we", 64'(we_o), 64'h1);
        chk("x0_a0", 64'(waddr_o[0]), 64'd7);
        chk("x0_d0", wdata_o[0], 64'h11);
        chk("x0_d1_zero", wdata_o[1], 64'h0);
        tick();
        chk("x0_empty", 64'(empty_o), 64'h1);

        // Fill to full under stall, then drain 2 per cycle
        stall_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            lanes(2'b11, 5'(10 + 2 * c), 64'h100 + 64'(2 * c),
                  5'(11 + 2 * c), 64'h101 + 64'(2 * c));
            #1;
            chk("fill_ready", 64'(in_ready_o), 64'h1);
            chk("fill_we", 64'(we_o), 64'h0);
            tick();
        end
        lanes(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        #1;
        chk("full_flag", 64'(full_o), 64'h1);
        chk("full_ready", 64'(in_ready_o), 64'h0);
        chk("full_count", 64'(count_o), 64'd8);
        chk("full_we", 64'(we_o), 64'h0);
        stall_i = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("drain_we", 64'(we_o), 64'h3);
            chk("drain_a0", 64'(waddr_o[0]), 64'(10 + 2 * c));
            chk("drain_a1", 64'(waddr_o[1]), 64'(11 + 2 * c));
            chk("drain_d0", wdata_o[0], 64'h100 + 64'(2 * c));
            chk("drain_d1", wdata_o[1], 64'h101 + 64'(2 * c));
            chk("drain_count", 64'(count_o), 64'(8 - 2 * c));
            chk("drain_ready", 64'(in_ready_o), 64'(c >= 1));
            tick();
        end
        chk("drain_done", 64'(count_o), 64'd0);

        // Same address in one group: younger value lands
        lanes(2'b11, 5'd9, 64'h1, 5'd9, 64'h2);
        #1;
        tick();
        lanes(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        #1;
        chk("same_a0", 64'(waddr_o[0]), 64'd9);
        chk("same_a1", 64'(waddr_o[1]), 64'd9);
        chk("same_d0", wdata_o[0], 64'h1);
        chk("same_d1", wdata_o[1], 64'h2);
        tick();
        chk("same_rf_x9", rf[9], 64'h2);

        // Wrap: 20 single-lane results, random stalls, scoreboarded
        i_enq = 0;
        cyc   = 0;
        while ((i_enq < 20 || q_a.size() != 0) && cyc < 300) begin
            stall_i = (i_enq < 20) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (i_enq < 20) begin
                lanes(2'b01, 5'(i_enq + 1), 64'h1000 + 64'(i_enq),
                      5'd0, 64'h0);
            end else begin
                lanes(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
            end
            #1;
            exp_rdy = (8 - q_a.size()) >= 2;
            n_exp = stall_i ? 0 : (q_a.size() < 2 ? q_a.size() : 2);
            chk("wrap_count", 64'(count_o), 64'(q_a.size()));
            chk("wrap_max", 64'(count_o <= 4'd8), 64'h1);
            chk("wrap_ready", 64'(in_ready_o), 64'(exp_rdy));
            for (int k = 0; k < 2; k++) begin
                if (k < n_exp) begin
                    chk("wrap_we", 64'(we_o[k]), 64'h1);
                    chk("wrap_addr", 64'(waddr_o[k]), 64'(q_a[k]));
                    chk("wrap_data", wdata_o[k], q_d[k]);
                end else begin
                    chk("wrap_we_off", 64'(we_o[k]), 64'h0);
                end
            end
            tick();
            for (int k = 0; k < n_exp; k++) begin
                void'(q_a.pop_front());
                void'(q_d.pop_front());
            end
            if (i_enq < 20 && exp_rdy) begin
                q_a.push_back(5'(i_enq + 1));
                q_d.push_back(64'h1000 + 64'(i_enq));
                i_enq++;
            end
            cyc++;
        end
        chk("wrap_timeout", 64'(cyc < 300), 64'h1);
        chk("wrap_empty", 64'(empty_o), 64'h1);

        // Reset with 5 entries queued: none may be issued
        stall_i = 1'b1;
        lanes(2'b11, 5'd1, 64'hB1, 5'd2, 64'hB2);
        tick();
        lanes(2'b11, 5'd3, 64'hB3, 5'd4, 64'hB4);
        tick();
        lanes(2'b01, 5'd5, 64'hB5, 5'd0, 64'h0);
        tick();
        lanes(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        #1;
        chk("prerst_count", 64'(count_o), 64'd5);
`ifdef REGFILE_WB_QUEUE_FWD_EN
        fwd_raddr_i[0] = 5'd3;
        fwd_raddr_i[1] = 5'd9;
        #1;
        chk("fwd_hit_b3", 64'(fwd_hit_o[0]), 64'h1);
        chk("fwd_data_b3", fwd_data_o[0], 64'hB3);
        chk("fwd_miss", 64'(fwd_hit_o[1]), 64'h0);
        chk("fwd_miss_data", fwd_data_o[1], 64'h0);
`endif
        rst_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        stall_i = 1'b0;
        #1;
        chk("midrst_count", 64'(count_o), 64'd0);
        chk("midrst_we", 64'(we_o), 64'h0);
        chk("midrst_empty", 64'(empty_o), 64'h1);
        chk("midrst_ready", 64'(in_ready_o), 64'h1);
        tick();
        chk("midrst_we2", 64'(we_o), 64'h0);

`ifdef REGFILE_WB_QUEUE_FWD_EN
        // x3 queued twice: youngest value forwards
        stall_i = 1'b1;
        lanes(2'b11, 5'd3, 64'h10, 5'd3, 64'h20);
        tick();
        lanes(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        fwd_raddr_i[0] = 5'd3;
        fwd_raddr_i[1] = 5'd0;
        #1;
        chk("fwd_hit_x3", 64'(fwd_hit_o[0]), 64'h1);
        chk("fwd_data_x3", fwd_data_o[0], 64'h20);
        chk("fwd_x0_miss", 64'(fwd_hit_o[1]), 64'h0);
        stall_i = 1'b0;
        #1;
        chk("fwd_draining", 64'(fwd_hit_o[0]), 64'h1);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
